alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; opcode and flag types SHALL be alu_op_t and alu_flags_t ({n,z,c,v}) from alu_pkg.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester (index 0/1) request valid
- req_ready  out  2  per-requester request accepted this cycle
- req_op0, req_op1  in  alu_op_t  requested operation
- req_a0, req_a1, req_b0, req_b1  in  32  operands
- req_setflags  in  2  per-requester: update flag register on completion
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index that owns the result
- rsp_data  out  32  ALU result
- rsp_flags  out  alu_flags_t  flags produced by this operation
- apsr_flags  out  alu_flags_t  architectural NZCV register
- busy  out  1  high whenever the state is not IDLE

Function
REQ-003 The block SHALL contain exactly one Alu instance, fed only from internal operand registers.
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP and SHALL start in IDLE.
REQ-005 In IDLE with any req_valid bit high, the block SHALL grant exactly one requester, assert that requester's req_ready combinationally in the same cycle, latch its op, a, b, setflags and id, and go to EXEC.
REQ-006 req_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-007 In EXEC, the block SHALL register the Alu data_out into rsp_data and flags_out into rsp_flags, and go to RESP.
REQ-008 In EXEC with the latched setflags=1, apsr_flags SHALL load the Alu flags on the same edge; with setflags=0, apsr_flags SHALL be unchanged.
REQ-009 In RESP, rsp_valid SHALL be 1, with rsp_id, rsp_data and rsp_flags held stable until the handshake.
REQ-010 In RESP with rsp_ready=1, the FSM SHALL return to IDLE on that edge; with rsp_ready=0, the FSM SHALL stay in RESP indefinitely.
REQ-011 Latency SHALL be fixed: a request accepted in cycle N gives rsp_valid=1 in cycle N+2.
REQ-012 Maximum throughput SHALL be one operation per 3 cycles.
REQ-013 A requester that drops req_valid before being granted SHALL be ignored, with no side effects.
REQ-014 Requester inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-015 Arbitration on simultaneous req_valid SHALL follow REQ-022/REQ-023; a single valid requester SHALL always be granted.

Reset
REQ-016 On rst_n low, the block SHALL asynchronously force state=IDLE.
REQ-017 On rst_n low, the block SHALL asynchronously clear rsp_valid, rsp_id, rsp_data, rsp_flags, apsr_flags and the operand registers to 0.
REQ-018 On rst_n low, the block SHALL asynchronously set the round-robin pointer to requester 0.
REQ-019 During reset, req_ready and busy SHALL be 0.
REQ-020 Reset asserted in EXEC or RESP SHALL abort the operation, leaving no pending response and no apsr_flags update.
REQ-021 The block SHALL leave reset synchronously to clk on the first rising edge with rst_n high.

Configuration
REQ-022 With macro ALU_ARBITER_RR_EN defined, arbitration SHALL be round-robin: when both are valid, the requester named by the pointer wins, and after every grant the pointer SHALL point to the other requester.
REQ-023 With ALU_ARBITER_RR_EN undefined, arbitration SHALL be fixed priority (requester 0 wins ties), and the pointer logic SHALL be absent.

Verification
REQ-024 The bench SHALL cover these scenarios:
- req0 ADD a=0xFFFFFFFF b=0x1 setflags=1 -> rsp cycle N+2: data=0x0, id=0, rsp_flags z=1 c=1 n=0 v=0, apsr_flags equal
- req1 SUB a=5 b=5 setflags=0 after apsr={1,0,0,0} -> data=0, rsp_flags z=1 c=1, apsr_flags remains {1,0,0,0}
- both valid every cycle, rsp_ready=1, ALU_ARBITER_RR_EN defined -> grant order 0,1,0,1; undefined -> 0,0,0,0
- rsp_ready held 0 for 4 cycles in RESP -> rsp_valid/data/id stable, req_ready=0 for both, accepted on cycle rsp_ready=1
- rst_n pulled low in EXEC of ADD 0x7FFFFFFF+1 setflags=1 -> no rsp_valid, apsr_flags=0, next request granted to requester 0
- LSL a=0x80000001 b=1 via req1 -> data=0x00000002, rsp_flags c=1 z=0 n=0

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter -- two-requester front end for a single shared 32-bit ALU.
//
// Configuration macro: ALU_ARBITER_RR_EN
//   defined   : round-robin arbitration between the two requesters
//   undefined : fixed priority, requester 0 wins ties (no pointer state)
//
// Contents (in order): alu_pkg (opcode / flag types), alu (combinational
// datapath), alu_arbiter (top).
//
// alu_arbiter ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[1:0]      per-requester request valid
//   req_ready[1:0]      per-requester accept strobe (combinational, IDLE only)
//   req_op0/1           requested operation (alu_op_t)
//   req_a0/1, req_b0/1  32-bit operands
//   req_setflags[1:0]   update apsr_flags when the operation completes
//   rsp_valid/rsp_ready result handshake
//   rsp_id              requester that owns the result
//   rsp_data            ALU result
//   rsp_flags           NZCV produced by this operation
//   apsr_flags          architectural NZCV register
//   busy                high whenever the FSM is not IDLE
//
// Timing: accept in cycle N (IDLE), compute in N+1 (EXEC), rsp_valid in N+2
// (RESP), held until rsp_ready. One operation per three cycles at best.
// -----------------------------------------------------------------------------

package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_EOR = 3'd4,
        ALU_LSL = 3'd5,
        ALU_LSR = 3'd6,
        ALU_ASR = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// -----------------------------------------------------------------------------
// alu -- purely combinational.
//   op, a, b      operation and operands
//   data_out      result
//   flags_out     NZCV for this result
// Carry follows the ARM convention: SUB sets C when no borrow occurs; shifts
// put the last bit shifted out into C (0 for a zero shift amount). Only
// b[4:0] is used as the shift amount. Logic ops and shifts clear V.
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  alu_op_t      op,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    output logic [31:0]  data_out,
    output alu_flags_t   flags_out
);

    logic [32:0]        add_ext;
    logic [32:0]        sub_ext;
    logic [32:0]        lsl_ext;
    logic [32:0]        lsr_ext;
    logic signed [32:0] asr_ext;
    logic [4:0]         shamt;
    logic [31:0]        res;
    logic               carry;
    logic               ovf;

    assign shamt   = b[4:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: bit 32 is the "no borrow" carry.
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + 33'd1;
    // One guard bit on the shifted-out side catches the last bit lost.
    assign lsl_ext = {1'b0, a} << shamt;
    assign lsr_ext = {a, 1'b0} >> shamt;
    assign asr_ext = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        res   = 32'd0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_ADD: begin
                res   = add_ext[31:0];
                carry = add_ext[32];
                ovf   = (a[31] == b[31]) && (add_ext[31] != a[31]);
            end
            ALU_SUB: begin
                res   = sub_ext[31:0];
                carry = sub_ext[32];
                ovf   = (a[31] != b[31]) && (sub_ext[31] != a[31]);
            end
            ALU_AND: res = a & b;
            ALU_ORR: res = a | b;
            ALU_EOR: res = a ^ b;
            ALU_LSL: begin
                res   = lsl_ext[31:0];
                carry = lsl_ext[32];
            end
            ALU_LSR: begin
                res   = lsr_ext[32:1];
                carry = lsr_ext[0];
            end
            ALU_ASR: begin
                res   = asr_ext[32:1];
                carry = asr_ext[0];
            end
            default: res = 32'd0;
        endcase
    end

    assign data_out    = res;
    assign flags_out.n = res[31];
    assign flags_out.z = (res == 32'd0);
    assign flags_out.c = carry;
    assign flags_out.v = ovf;

endmodule

// -----------------------------------------------------------------------------
// alu_arbiter -- top.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  alu_op_t      req_op0,
    input  alu_op_t      req_op1,
    input  logic [31:0]  req_a0,
    input  logic [31:0]  req_a1,
    input  logic [31:0]  req_b0,
    input  logic [31:0]  req_b1,
    input  logic [1:0]   req_setflags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [31:0]  rsp_data,
    output alu_flags_t   rsp_flags,
    output alu_flags_t   apsr_flags,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    alu_op_t     op_q,        op_d;
    logic [31:0] a_q,         a_d;
    logic [31:0] b_q,         b_d;
    logic        setflags_q,  setflags_d;
    logic        id_q,        id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q,    rsp_id_d;
    logic [31:0] rsp_data_q,  rsp_data_d;
    alu_flags_t  rsp_flags_q, rsp_flags_d;
    alu_flags_t  apsr_q,      apsr_d;
`ifdef ALU_ARBITER_RR_EN
    logic        rr_ptr_q,    rr_ptr_d;
`endif

    logic        grant_en;
    logic        grant_id;
    logic [31:0] alu_data;
    alu_flags_t  alu_flags;

    // The ALU only ever sees the captured operands, so requester inputs may
    // change freely once a request has been accepted.
    alu u_alu (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .data_out  (alu_data),
        .flags_out (alu_flags)
    );

    // Arbitration. A lone valid requester always wins; ties go to the
    // pointer (round-robin) or to requester 0 (fixed priority).
    always_comb begin
`ifdef ALU_ARBITER_RR_EN
        grant_id = (&req_valid) ? rr_ptr_q : req_valid[1];
`else
        grant_id = req_valid[1] & ~req_valid[0];
`endif
        // rst_n gates the grant so req_ready stays low while reset is held.
        grant_en  = (state_q == IDLE) && rst_n && (|req_valid);
        req_ready = 2'b00;
        if (grant_en) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        setflags_d  = setflags_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        apsr_d      = apsr_q;
`ifdef ALU_ARBITER_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    op_d       = grant_id ? req_op1 : req_op0;
                    a_d        = grant_id ? req_a1  : req_a0;
                    b_d        = grant_id ? req_b1  : req_b0;
                    setflags_d = req_setflags[grant_id];
                    id_d       = grant_id;
`ifdef ALU_ARBITER_RR_EN
                    rr_ptr_d   = ~grant_id;
`endif
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_data;
                rsp_flags_d = alu_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                if (setflags_q) begin
                    apsr_d = alu_flags;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= ALU_ADD;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            setflags_q  <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_flags_q <= '0;
            apsr_q      <= '0;
`ifdef ALU_ARBITER_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            setflags_q  <= setflags_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            apsr_q      <= apsr_d;
`ifdef ALU_ARBITER_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign apsr_flags = apsr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter -- directed bench for alu_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge; the design acts on rising edges.
// Flag vectors below are written as {n,z,c,v}.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    alu_op_t     req_op0;
    alu_op_t     req_op1;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [1:0]  req_setflags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    alu_flags_t  rsp_flags;
    alu_flags_t  apsr_flags;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_a1       (req_a1),
        .req_b0       (req_b0),
        .req_b1       (req_b1),
        .req_setflags (req_setflags),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .apsr_flags   (apsr_flags),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction from an IDLE falling edge back to IDLE.
    // hold = number of RESP cycles with rsp_ready low before the handshake;
    // during those cycles both requesters are kept valid to show no grant.
    task automatic do_op(input string tag, input logic id, input alu_op_t op,
                         input logic [31:0] a, input logic [31:0] b, input logic sf,
                         input logic [31:0] exp_data, input logic [3:0] exp_flags,
                         input logic [3:0] exp_apsr, input int hold);
        logic [1:0] exp_ready;
        exp_ready = id ? 2'b10 : 2'b01;
        if (id) begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end
        req_setflags     = 2'b00;
        req_setflags[id] = sf;
        req_valid        = exp_ready;
        #1;
        chk({tag, ".ready_grant"}, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);                       // EXEC
        req_valid    = 2'b00;
        // Scramble the requester inputs; the in-flight result must not care.
        req_op0      = ALU_ORR; req_op1 = ALU_AND;
        req_a0       = 32'hDEAD_BEEF; req_a1 = 32'h1234_5678;
        req_b0       = 32'hCAFE_F00D; req_b1 = 32'h0BAD_F00D;
        req_setflags = ~req_setflags;
        chk({tag, ".exec_busy"},  32'(busy), 32'd1);
        chk({tag, ".exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);                       // RESP, cycle N+2
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".rsp_id"},    32'(rsp_id), 32'(id));
        chk({tag, ".rsp_data"},  rsp_data, exp_data);
        chk({tag, ".rsp_flags"}, 32'(rsp_flags), 32'(exp_flags));
        chk({tag, ".apsr"},      32'(apsr_flags), 32'(exp_apsr));
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            rsp_ready = 1'b0;
            #1;
            chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_data"},  rsp_data, exp_data);
            chk({tag, ".hold_id"},    32'(rsp_id), 32'(id));
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);                       // back in IDLE
        rsp_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".done_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_id;
        rst_n        = 1'b0;
        req_valid    = 2'b01;
        req_op0      = ALU_ADD;
        req_op1      = ALU_ADD;
        req_a0       = 32'd0;
        req_a1       = 32'd0;
        req_b0       = 32'd0;
        req_b1       = 32'd0;
        req_setflags = 2'b00;
        rsp_ready    = 1'b0;

        // Reset state, with a requester valid throughout.
        repeat (2) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.busy",      32'(busy), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_data",  rsp_data, 32'd0);
        chk("rst.apsr",      32'(apsr_flags), 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        @(negedge clk);

        // ADD wrap: 0xFFFFFFFF + 1 = 0, Z=1 C=1, flags written to APSR.
        do_op("add_wrap", 1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1,
              32'h0, 4'b0110, 4'b0110, 0);
        // SUB 0-1 = 0xFFFFFFFF, N=1 C=0 (borrow): APSR becomes {1,0,0,0}.
        do_op("sub_neg", 1'b0, ALU_SUB, 32'h0, 32'h1, 1'b1,
              32'hFFFF_FFFF, 4'b1000, 4'b1000, 0);
        // req1 SUB 5-5 without setflags: Z=1 C=1, APSR untouched.
        do_op("sub_eq", 1'b1, ALU_SUB, 32'd5, 32'd5, 1'b0,
              32'h0, 4'b0110, 4'b1000, 0);
        // req1 LSL by 1: bit 31 lands in C.
        do_op("lsl", 1'b1, ALU_LSL, 32'h8000_0001, 32'h1, 1'b0,
              32'h0000_0002, 4'b0010, 4'b1000, 0);
        // ASR by 4 of 0x80000000: sign-fill, last bit out (a[3]) = 0.
        do_op("asr", 1'b0, ALU_ASR, 32'h8000_0000, 32'h4, 1'b0,
              32'hF800_0000, 4'b1000, 4'b1000, 0);
        // Back-pressure: four RESP cycles with rsp_ready low.
        do_op("bp_eor", 1'b0, ALU_EOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0,
              32'h0FF0_0FF0, 4'b0000, 4'b1000, 4);

        // Reset during EXEC of ADD 0x7FFFFFFF+1 with setflags.
        req_op0 = ALU_ADD; req_a0 = 32'h7FFF_FFFF; req_b0 = 32'h1;
        req_setflags = 2'b01;
        req_valid    = 2'b01;
        #1;
        chk("rstx.grant", 32'(req_ready), 32'd1);
        @(negedge clk);                       // EXEC
        req_valid = 2'b00;
        chk("rstx.in_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstx.busy",      32'(busy), 32'd0);
        chk("rstx.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstx.apsr",      32'(apsr_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstx.after_valid", 32'(rsp_valid), 32'd0);
        chk("rstx.after_apsr",  32'(apsr_flags), 32'd0);
        chk("rstx.after_busy",  32'(busy), 32'd0);

        // Both requesters valid continuously, consumer always ready.
        req_op0 = ALU_ADD; req_a0 = 32'd10; req_b0 = 32'd1;
        req_op1 = ALU_ADD; req_a1 = 32'd20; req_b1 = 32'd2;
        req_setflags = 2'b00;
        req_valid    = 2'b11;
        rsp_ready    = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARBITER_RR_EN
            exp_id = k[0];
`else
            exp_id = 1'b0;
`endif
            #1;
            chk($sformatf("arb%0d.grant", k), 32'(req_ready),
                exp_id ? 32'd2 : 32'd1);
            @(negedge clk);                   // EXEC
            @(negedge clk);                   // RESP
            chk($sformatf("arb%0d.rsp_id", k), 32'(rsp_id), 32'(exp_id));
            chk($sformatf("arb%0d.rsp_data", k), rsp_data,
                exp_id ? 32'd22 : 32'd11);
            @(negedge clk);                   // IDLE again
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("end.busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
